// File: rtl/add_pkg.sv
// Shared definitions for the adder datapath: the 4-bit add unit, its
// interface and the downstream sum accumulator all size themselves from here.
//   OP_W        : adder operand width
//   SUM_W       : adder result width (one carry bit above the operands)
//   sum_t       : one adder result
//   acc_state_e : accumulator block state (collecting / result held)
package add_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SUM_W = 5;

  typedef logic [SUM_W-1:0] sum_t;

  typedef enum logic {
    ACC,
    DONE
  } acc_state_e;

endpackage

// File: rtl/sum_accum.sv
// Block accumulator for the adder result stream. Collects N unsigned samples
// under a valid/ready handshake, then holds the block total and the block
// maximum on an output handshake until downstream takes them.
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   clear     : synchronous abort of the current block (beats any handshake)
//   in_valid  : upstream sample valid
//   in_ready  : high while collecting; depends on state only
//   in_sum    : sample value, unsigned
//   out_valid : block result held
//   out_ready : downstream takes the result
//   out_acc   : sum of the N samples of the block
//   out_max   : largest sample of the block
//   count     : samples accepted in the current block
module sum_accum #(
  parameter int unsigned SUM_W = add_pkg::SUM_W,
  parameter int unsigned N     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_W-1:0]     in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_W+$clog2(N)-1:0] out_acc,
  output logic [SUM_W-1:0]     out_max,
  output logic [$clog2(N)-1:0] count
);

  import add_pkg::acc_state_e;
  import add_pkg::ACC;
  import add_pkg::DONE;

  // N samples of at most 2^SUM_W-1 each always fit, so no overflow handling.
  localparam int unsigned ACC_W = SUM_W + $clog2(N);
  localparam int unsigned CNT_W = $clog2(N);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N - 1);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [SUM_W-1:0] out_max_q, out_max_d;

  logic             accept;
  logic [ACC_W-1:0] acc_sum;
  logic [SUM_W-1:0] max_new;

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // Running values including the sample offered this cycle.
  assign acc_sum = acc_q + ACC_W'(in_sum);
  assign max_new = (in_sum > max_q) ? in_sum : max_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    max_d     = max_q;
    count_d   = count_q;
    out_acc_d = out_acc_q;
    out_max_d = out_max_q;

    if (clear) begin
      // Drops both a partial block and any pending result.
      state_d = ACC;
      acc_d   = '0;
      max_d   = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (accept) begin
            if (count_q == LastIdx) begin
              // Final sample: publish the result and start the next block clean,
              // so nothing needs resetting at the output handshake.
              out_acc_d = acc_sum;
              out_max_d = max_new;
              acc_d     = '0;
              max_d     = '0;
              count_d   = '0;
              state_d   = DONE;
            end else begin
              acc_d   = acc_sum;
              max_d   = max_new;
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      acc_q     <= '0;
      max_q     <= '0;
      count_q   <= '0;
      out_acc_q <= '0;
      out_max_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      max_q     <= max_d;
      count_q   <= count_d;
      out_acc_q <= out_acc_d;
      out_max_q <= out_max_d;
    end
  end

  assign out_acc = out_acc_q;
  assign out_max = out_max_q;
  assign count   = count_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum (N=4, SUM_W=5): expected block results are
// computed from the driven samples, queued, and compared when the DUT
// presents them.
module tb_sum_accum;

  localparam int unsigned SUM_W = 5;
  localparam int unsigned N     = 4;
  localparam int unsigned ACC_W = SUM_W + $clog2(N);
  localparam int unsigned CNT_W = $clog2(N);

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [SUM_W-1:0] out_max;
  logic [CNT_W-1:0] count;

  sum_accum #(
    .SUM_W(SUM_W),
    .N    (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_max  (out_max),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entries: {acc, max}.
  logic [ACC_W+SUM_W-1:0] exp_q[$];

  // Reference block state.
  int m_acc = 0;
  int m_max = 0;
  int m_cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_max = 0;
    m_cnt = 0;
  endtask

  // Offer one sample, wait (bounded) until it is accepted, update the model.
  task automatic accept(input int x);
    int t;
    in_valid = 1'b1;
    in_sum   = SUM_W'(x);
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    chk("in_ready_before_accept", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    m_acc += x;
    if (x > m_max) m_max = x;
    m_cnt++;
    if (m_cnt == N) begin
      exp_q.push_back({ACC_W'(m_acc), SUM_W'(m_max)});
      model_reset();
    end
    chk("count_after_accept", int'(count), m_cnt);
  endtask

  // Wait (bounded) for a result and compare it with the oldest expectation.
  task automatic expect_result(input string tag);
    int t;
    logic [ACC_W+SUM_W-1:0] e;
    t = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    chk({tag, "_out_valid"}, int'(out_valid), 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_out_acc"}, int'(out_acc), int'(e[ACC_W+SUM_W-1:SUM_W]));
      chk({tag, "_out_max"}, int'(out_max), int'(e[SUM_W-1:0]));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset values.
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    chk("rst_out_max", int'(out_max), 0);
    chk("rst_count", int'(count), 0);

    // Back-to-back block with downstream always ready.
    out_ready = 1'b1;
    accept(7);
    accept(5);
    accept(7);
    chk("b1_no_early_valid", int'(out_valid), 0);
    accept(8);
    chk("b1_in_ready_low", int'(in_ready), 0);
    expect_result("b1");
    tick();
    chk("b1_valid_dropped", int'(out_valid), 0);
    chk("b1_in_ready_back", int'(in_ready), 1);

    // Largest samples: total must not saturate or wrap.
    accept(31);
    accept(31);
    accept(31);
    accept(31);
    expect_result("full_scale");
    tick();

    // Backpressure: result held while upstream keeps offering.
    out_ready = 1'b0;
    accept(1);
    accept(2);
    accept(3);
    accept(4);
    in_valid = 1'b1;
    in_sum   = SUM_W'(9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_acc", int'(out_acc), 10);
      chk("bp_out_max", int'(out_max), 4);
      chk("bp_count", int'(count), 0);
    end
    in_valid = 1'b0;
    expect_result("bp");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_released", int'(out_valid), 0);
    chk("bp_in_ready_back", int'(in_ready), 1);

    // Clear mid-block discards the partial sum and the sample offered with it.
    out_ready = 1'b1;
    accept(9);
    accept(9);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = SUM_W'(3);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    chk("clr_count", int'(count), 0);
    accept(1);
    accept(1);
    accept(1);
    accept(1);
    expect_result("clr");
    tick();

    // Asynchronous reset between edges.
    accept(5);
    accept(6);
    accept(7);
    rst_n = 1'b0;
    #1;
    chk("arst_out_acc", int'(out_acc), 0);
    chk("arst_out_max", int'(out_max), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_valid", int'(out_valid), 0);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    accept(2);
    accept(2);
    accept(2);
    accept(2);
    expect_result("arst");
    tick();

    // Gapped input: count moves only on accepting cycles.
    accept(4);
    tick();
    chk("gap_count_hold1", int'(count), 1);
    accept(6);
    tick();
    chk("gap_count_hold2", int'(count), 2);
    accept(2);
    tick();
    chk("gap_count_hold3", int'(count), 3);
    accept(3);
    expect_result("gap");
    tick();

    // Clear together with the final accept: no result.
    accept(1);
    accept(2);
    accept(3);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = SUM_W'(4);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    chk("clr_last_no_valid", int'(out_valid), 0);
    chk("clr_last_count", int'(count), 0);
    tick();
    chk("clr_last_still_no_valid", int'(out_valid), 0);

    // Clear together with the output handshake: result dropped.
    out_ready = 1'b0;
    accept(1);
    accept(1);
    accept(1);
    accept(1);
    chk("clr_hs_valid", int'(out_valid), 1);
    void'(exp_q.pop_front());
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    chk("clr_hs_valid_dropped", int'(out_valid), 0);
    chk("clr_hs_in_ready", int'(in_ready), 1);
    chk("clr_hs_count", int'(count), 0);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
# sum_accum

Sequential accumulator stage sitting directly downstream of the 4-bit `add` unit. It consumes the 5-bit `sum` stream under a valid/ready handshake and accumulates a fixed block of N samples. It then presents the block total and block maximum on an output handshake. This provides the first clocked, flow-controlled consumer of adder results in the datapath.

## Interface
Parameters:
- `SUM_W`, default 5, width of incoming sum (matches adder output).
- `N`, default 4, samples per block; legal range 2..256.
- `ACC_W`, derived localparam = `SUM_W + $clog2(N)`, output accumulator width. No overflow is possible.

Ports:
- `clk`, input, 1, single clock; all state updates on rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `clear`, input, 1, synchronous abort of the current block.
- `in_valid`, input, 1, upstream sample valid.
- `in_ready`, output, 1, block can accept a sample.
- `in_sum`, input, SUM_W, sample value (unsigned).
- `out_valid`, output, 1, block result available.
- `out_ready`, input, 1, downstream accepts result.
- `out_acc`, output, ACC_W, sum of the N samples of the block.
- `out_max`, output, SUM_W, largest sample of the block.
- `count`, output, `$clog2(N)`, samples accepted in the current block.

## Operation
- Two states:
  - ACC: collecting samples; `in_ready=1`, `out_valid=0`.
  - DONE: result held; `in_ready=0`, `out_valid=1`.
- Accept occurs when `in_valid && in_ready`:
  - `acc <= acc + in_sum`.
  - `max <= (in_sum > max) ? in_sum : max`.
  - `count <= count + 1`.
- On the accept where `count == N-1`:
  - The final sum and max are registered into `out_acc`/`out_max`.
  - `count` wraps to 0 and state goes to DONE.
- In DONE, `out_acc`, `out_max` and `count` are frozen. Upstream samples are not consumed.
- On `out_valid && out_ready`:
  - State returns to ACC.
  - Internal `acc` and `max` are 0 for the new block.
  - `out_acc` and `out_max` keep their last values, which are don't-care while `out_valid=0`.
- `clear` (synchronous, priority above any handshake):
  - Sets state to ACC and zeroes `acc`, `max` and `count`.
  - Drops any pending result (`out_valid` falls the next cycle).
  - A sample presented in the same cycle is discarded even if `in_valid=1`.
- Arithmetic is unsigned. `in_sum` is zero-extended to ACC_W before the add.

## Timing
- Reset (async assert, sync release) values:
  - State is ACC, with `in_ready=1` and `out_valid=0`.
  - `out_acc=0`, `out_max=0`, `count=0`.
- Latency: `out_valid` rises 1 cycle after the Nth accepting edge.
- No combinational path from `out_ready` to `in_ready`. After result handoff, `in_ready` rises the cycle after the `out_ready` edge, giving a 1-cycle bubble per block.
- `in_ready` depends only on state, never on `in_valid`.
- Output stability: while `out_valid=1 && out_ready=0`, `out_acc` and `out_max` must not change.
- Reset asserted mid-block or during DONE returns all outputs to reset values immediately. The partial block is lost.
- Simultaneous events:
  - `clear` together with the final accept: clear wins, and no result is produced.
  - `clear` together with the output handshake: clear wins. The result counts as dropped, and the block returns to ACC either way.

## Structure
- Shared package `add_pkg` holds:
  - `SUM_W = 5` and `OP_W = 4`.
  - `typedef logic [SUM_W-1:0] sum_t`.
  - The state enum `acc_state_e {ACC, DONE}`.
- The upstream `add` and `add_if` reuse `OP_W`/`SUM_W` from this package.
- Single module, no sub-module. Counter, accumulator, max register and two-state FSM are small enough to live together.
- Bench-side interface `sum_stream_if` (valid/ready/data) for both in and out ports.

## Test plan
- N=4, samples 7, 5, 7, 8 back-to-back with `out_ready=1` → `out_valid` 1 cycle after the 4th accept, `out_acc=27`, `out_max=8`, then `in_ready` high on the following cycle.
- Saturation-free check: N=4, four samples of 31 → `out_acc=124` (fits ACC_W=7), `out_max=31`.
- Backpressure: complete a block with `out_ready=0` for 3 cycles while `in_valid=1` → `in_ready=0`, outputs stable for all 3 cycles, no sample consumed, `count` frozen at 0.
- Clear mid-block: accept 9 and 9, assert `clear` with sample 3 valid, then samples 1, 1, 1, 1 → `out_acc=4`, `out_max=1`.
- Async reset mid-block: after 3 accepts, pulse `rst_n` low between edges → outputs zero immediately, `count=0`, next 4 samples of 2 give `out_acc=8`.
- Gapped input: samples 4, 6, 2, 3 with `in_valid` low on alternate cycles → `out_acc=15`, `out_max=6`, `count` increments only on accepting cycles.
